idct_8x8: RTL and testbench

// - 8x8 2-D inverse DCT, X = A^T * Y * A, for the JPEG decode/loopback path; the inverse of the forward DCT.
// - Uses the same orthonormal 8-point DCT matrix A as the forward transform, in signed fixed point Q1.14.
// - Accepts 64 dequantised coefficients in raster order (u row, v column) and emits 64 level-shifted 8-bit pixels.
// - Single multiply-accumulate (MAC) datapath, reused over two passes: column pass, then row pass.

---
 rtl/idct_pkg.sv | 28 ++
 rtl/idct_coef_rom.sv | 18 +
 rtl/idct_8x8.sv | 193 +++++++++++++++++++
 tb/tb_idct_8x8.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared types and constants for the 8x8 inverse DCT.
// Holds the datapath widths, the FSM state type and the Q1.14 orthonormal
// DCT-II matrix A, stored row-major as IDCT_A[u*8 + x].
package idct_pkg;

  localparam int unsigned CW    = 12;  // coefficient input width, signed
  localparam int unsigned QF    = 14;  // fractional bits of A
  localparam int unsigned TW    = 16;  // intermediate T width, signed
  localparam int unsigned AW    = 16;  // matrix entry width, signed
  localparam int unsigned PW    = 32;  // full-precision TW x AW product
  localparam int unsigned ACC_W = 35;  // 8-term accumulator width
  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {LOAD, PASS1, PASS2, OUT} idct_state_t;

  // A[u][x] = c(u) * cos((2x+1) u pi / 16), c(0) = sqrt(1/8), c(u>0) = 1/2.
  localparam logic signed [AW-1:0] IDCT_A [64] = '{
    16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
    16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
    16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
    16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
    16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
    16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
    16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
    16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
  };

endpackage

// File: rtl/idct_coef_rom.sv
// Combinational lookup of one column of the DCT matrix.
// Ports:
//   idx_i  in   3      column index x
//   col_o  out  8x16   A[u][x] for u = 0..7
module idct_coef_rom
  import idct_pkg::*;
(
  input  logic [2:0]           idx_i,
  output logic signed [AW-1:0] col_o [8]
);

  always_comb begin
    for (int u = 0; u < 8; u++) begin
      col_o[u] = IDCT_A[{3'(u), idx_i}];
    end
  end

endmodule

// File: rtl/idct_8x8.sv
// 8x8 2-D inverse DCT, X = A^T * Y * A, on a single 8-product MAC datapath
// reused for a column pass (T = A^T * Y) and a row pass (X = T * A).
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    coefficient valid
//   in_ready   out  1    block accepts a coefficient (LOAD only)
//   in_data    in   CW   signed coefficient Y[u][v], raster order
//   out_valid  out  1    pixel valid
//   out_ready  in   1    sink accepts pixel
//   out_data   out  8    level-shifted pixel X[i][j], raster order
//   out_last   out  1    high with pixel 63 only
module idct_8x8
  import idct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_data,
  output logic                 out_last
);

  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(2 ** (QF - 1));
  localparam logic signed [ACC_W-1:0] T_MAX    = ACC_W'(2 ** (TW - 1) - 1);
  localparam logic signed [ACC_W-1:0] T_MIN    = ACC_W'(-(2 ** (TW - 1)));
  localparam logic signed [ACC_W-1:0] LVL      = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'(255);

  idct_state_t         state_q;
  logic [5:0]          cnt_q;
  logic [5:0]          cnt_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [PIX_W-1:0]    out_data_q;
  logic                out_last_q;

  logic signed [CW-1:0] y_q    [64];
  logic signed [TW-1:0] t_q    [64];
  logic [PIX_W-1:0]     obuf_q [64];

  logic [2:0]              rom_idx;
  logic signed [AW-1:0]    a_col [8];
  logic signed [TW-1:0]    opnd  [8];
  logic signed [PW-1:0]    prod  [8];
  logic signed [ACC_W-1:0] sum4  [4];
  logic signed [ACC_W-1:0] sum2  [2];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] lvl;
  logic signed [TW-1:0]    t_sat;
  logic [PIX_W-1:0]        pix;
  logic                    load_xfer;
  logic                    out_xfer;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign cnt_d     = cnt_q + 6'd1;
  assign load_xfer = (state_q == LOAD) && in_valid && in_ready_q;
  assign out_xfer  = (state_q == OUT) && out_valid_q && out_ready;

  // PASS1 needs column i of A (i = cnt[5:3]); PASS2 needs column j (j = cnt[2:0]).
  assign rom_idx = (state_q == PASS1) ? cnt_q[5:3] : cnt_q[2:0];

  idct_coef_rom u_rom (
    .idx_i (rom_idx),
    .col_o (a_col)
  );

  // Operand fan-in: Y column v in PASS1, T row i in PASS2.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      opnd[n] = '0;
      if (state_q == PASS1) begin
        opnd[n] = TW'(y_q[{3'(n), cnt_q[2:0]}]);
      end else begin
        opnd[n] = t_q[{cnt_q[5:3], 3'(n)}];
      end
    end
  end

  // Full-precision products and balanced adder tree.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      prod[n] = PW'(opnd[n]) * PW'(a_col[n]);
    end
    for (int n = 0; n < 4; n++) begin
      sum4[n] = ACC_W'(prod[2*n]) + ACC_W'(prod[2*n+1]);
    end
    sum2[0] = sum4[0] + sum4[1];
    sum2[1] = sum4[2] + sum4[3];
    acc     = sum2[0] + sum2[1];
  end

  // Half-up rounding, then T saturation and pixel level shift / clamp.
  always_comb begin
    rnd = (acc + RND_BIAS) >>> QF;
    lvl = rnd + LVL;

    if (rnd > T_MAX) begin
      t_sat = {1'b0, {(TW-1){1'b1}}};
    end else if (rnd < T_MIN) begin
      t_sat = {1'b1, {(TW-1){1'b0}}};
    end else begin
      t_sat = TW'(rnd);
    end

    if (lvl < 0) begin
      pix = '0;
    end else if (lvl > PIX_MAX) begin
      pix = '1;
    end else begin
      pix = PIX_W'(lvl);
    end
  end

  // Block storage; contents are fully rewritten each block, so no reset.
  always_ff @(posedge clk) begin
    if (load_xfer) begin
      y_q[cnt_q] <= in_data;
    end
    if (state_q == PASS1) begin
      t_q[cnt_q] <= t_sat;
    end
    if (state_q == PASS2) begin
      obuf_q[cnt_q] <= pix;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_xfer) begin
            cnt_q <= cnt_d;
            if (cnt_q == 6'd63) begin
              state_q    <= PASS1;
              in_ready_q <= 1'b0;
            end
          end
        end
        PASS1: begin
          cnt_q <= cnt_d;
          if (cnt_q == 6'd63) begin
            state_q <= PASS2;
          end
        end
        PASS2: begin
          cnt_q <= cnt_d;
          if (cnt_q == 6'd63) begin
            // Pixel 0 was written at PASS2 cycle 0, so it is already in obuf.
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= obuf_q[0];
            out_last_q  <= 1'b0;
          end
        end
        OUT: begin
          if (out_xfer) begin
            cnt_q <= cnt_d;
            if (cnt_q == 6'd63) begin
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              out_data_q <= obuf_q[cnt_d];
              out_last_q <= (cnt_d == 6'd63);
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_8x8.sv
// Self-checking bench for idct_8x8: directed DC/zero/clamp/backpressure/reset
// blocks plus random blocks against a double-precision IDCT scoreboard.
module tb_idct_8x8;

  localparam int BOUND = 3000;
  localparam real PI = 3.14159265358979323846;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic               out_last;

  typedef struct {
    int pix;
    int tol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   bp_mode  = 1'b0;
  bit   abort    = 1'b0;
  real  amat [8][8];

  idct_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  task automatic push_const(input int v);
    exp_t e;
    e.pix = v;
    e.tol = 0;
    for (int k = 0; k < 64; k++) sb.push_back(e);
  endtask

  // Reference: X = A^T Y A in double precision, +128, rounded and clamped.
  task automatic push_model(input int y [64]);
    real  s;
    int   r;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        s = 128.0;
        for (int u = 0; u < 8; u++) begin
          for (int v = 0; v < 8; v++) begin
            s = s + amat[u][i] * real'(y[u*8+v]) * amat[v][j];
          end
        end
        r = $rtoi($floor(s + 0.5));
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        e.pix = r;
        e.tol = 1;
        sb.push_back(e);
      end
    end
  endtask

  // Drive 64 coefficients; gap_pct inserts idle in_valid cycles.
  task automatic send_block(input int y [64], input int gap_pct);
    int n;
    if (abort) return;
    for (int k = 0; k < 64; k++) begin
      in_valid = 1'b1;
      in_data  = 12'(y[k]);
      n = 0;
      while (!in_ready && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      if (n >= BOUND) begin
        check("in_ready_timeout", 0, 1, 0);
        abort    = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 12'($urandom_range(0, 4095));
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 5 * BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5 * BOUND) begin
      check("drain_timeout", 0, 1, 0);
      abort = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: chooses out_ready, pops the scoreboard on each transfer.
  initial begin
    int   pix_idx;
    bit   stalled;
    bit   rdy_back;
    bit   rdy;
    int   held_data;
    int   held_last;
    exp_t e;
    pix_idx   = 0;
    stalled   = 1'b0;
    rdy_back  = 1'b0;
    held_data = 0;
    held_last = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pix_idx   = 0;
        stalled   = 1'b0;
        rdy_back  = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (rdy_back) begin
          check("in_ready_after_last", int'(in_ready), 1, 0);
          check("valid_drop_after_last", int'(out_valid), 0, 0);
          rdy_back = 1'b0;
        end
        if (stalled && out_valid) begin
          check("hold_data", int'(out_data), held_data, 0);
          check("hold_last", int'(out_last), held_last, 0);
        end
        rdy = bp_mode ? (int'($urandom_range(0, 99)) < 30) : 1'b1;
        out_ready = rdy;
        if (out_valid && rdy) begin
          if (sb.size() == 0) begin
            check("unexpected_pixel", 1, 0, 0);
          end else begin
            e = sb.pop_front();
            check("pixel", int'(out_data), e.pix, e.tol);
          end
          check("out_last", int'(out_last), (pix_idx == 63) ? 1 : 0, 0);
          if (pix_idx == 63) begin
            check("in_ready_busy", int'(in_ready), 0, 0);
            rdy_back = 1'b1;
          end
          pix_idx = (pix_idx + 1) % 64;
          stalled = 1'b0;
        end else begin
          stalled   = out_valid;
          held_data = int'(out_data);
          held_last = int'(out_last);
        end
      end
    end
  end

  initial begin
    int blk [64];
    int e0;
    int n;

    for (int u = 0; u < 8; u++) begin
      for (int x = 0; x < 8; x++) begin
        amat[u][x] = ((u == 0) ? $sqrt(0.125) : 0.5) * $cos(real'((2 * x + 1) * u) * PI / 16.0);
      end
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_data", int'(out_data), 0, 0);
    check("rst_out_last", int'(out_last), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // DC block
    for (int k = 0; k < 64; k++) blk[k] = 0;
    blk[0] = 64;
    push_const(136);
    send_block(blk, 0);
    check("in_ready_after_load", int'(in_ready), 0, 0);

    // Zero block with latency measurement
    wait_drain();
    for (int k = 0; k < 64; k++) blk[k] = 0;
    push_const(128);
    send_block(blk, 0);
    e0 = cyc;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latency", cyc - e0, 128, 0);

    // Clamp high and low
    blk[0] = 2047;
    push_const(255);
    send_block(blk, 0);
    blk[0] = -2048;
    push_const(0);
    send_block(blk, 0);

    // Backpressure
    wait_drain();
    bp_mode = 1'b1;
    blk[0] = 64;
    push_const(136);
    send_block(blk, 0);
    wait_drain();
    bp_mode = 1'b0;

    // Reset in PASS2 at cnt=20; block is discarded
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
    send_block(blk, 0);
    e0 = cyc;
    n = 0;
    while (cyc < e0 + 84 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0, 0);
    check("midrst_in_ready", int'(in_ready), 1, 0);
    check("midrst_out_last", int'(out_last), 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", int'(out_valid), 0, 0);

    for (int k = 0; k < 64; k++) blk[k] = 0;
    blk[0] = 64;
    push_const(136);
    send_block(blk, 10);

    // Random blocks against the double-precision model
    for (int b = 0; b < 40; b++) begin
      if (abort) break;
      wait_drain();
      bp_mode = b[0];
      for (int k = 0; k < 64; k++) begin
        if (b % 2 == 0) blk[k] = int'($urandom_range(0, 4095)) - 2048;
        else            blk[k] = int'($urandom_range(0, 200)) - 100;
      end
      push_model(blk);
      send_block(blk, (b % 3 == 0) ? 20 : 0);
    end

    wait_drain();
    check("scoreboard_empty", sb.size(), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
